// File: rtl/spike_packer_if.sv
// Output handshake bundle for the spike packer.
// The master presents packed words and the slave accepts them.
interface spike_packer_if;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [3:0] out_count;

  modport master (
    output out_valid,
    output out_data,
    output out_count,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_count,
    output out_ready
  );
endinterface

// File: rtl/spike_packer.sv
// Packs serial spike bits into bytes (bit0 earliest) and queues them
// in a small FIFO with drop-on-full and a saturating spike counter.
module spike_packer #(
  parameter int DEPTH = 4
) (
  input  logic                CLK100MHZ,
  input  logic                reset_n,
  input  logic                spike_in,
  input  logic                spike_valid,
  input  logic                flush,
  spike_packer_if.master      bus,
  output logic                full,
  output logic                overflow,
  output logic [15:0]         spike_total
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_OCC = DEPTH[AW:0];

  logic [7:0]    shift_reg;
  logic [2:0]    bit_cnt;
  logic [11:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   occ;

  logic [7:0]    word;
  logic [3:0]    nbits;
  logic          push;
  logic          pop;
  logic          accept;
  logic          head_ok;

  // The incoming bit is merged before any flush decision.
  always_comb begin
    word  = shift_reg;
    nbits = {1'b0, bit_cnt};
    push  = flush && (bit_cnt != 3'd0);
    if (spike_valid) begin
      word  = shift_reg | (8'(spike_in) << bit_cnt);
      nbits = {1'b0, bit_cnt} + 4'd1;
      push  = flush || (bit_cnt == 3'd7);
    end
  end

  assign head_ok = (occ != '0);
  assign full    = (occ == FULL_OCC);
  assign pop     = head_ok && bus.out_ready;
  assign accept  = push && (!full || pop);

  assign bus.out_valid = head_ok;
  assign bus.out_data  = head_ok ? mem[rd_ptr][7:0]  : 8'd0;
  assign bus.out_count = head_ok ? mem[rd_ptr][11:8] : 4'd0;

  always_ff @(posedge CLK100MHZ) begin
    if (accept) mem[wr_ptr] <= {nbits, word};
  end

  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg   <= '0;
      bit_cnt     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occ         <= '0;
      overflow    <= 1'b0;
      spike_total <= '0;
    end else begin
      // A dropped word still clears the packer.
      if (push) begin
        shift_reg <= '0;
        bit_cnt   <= '0;
      end else if (spike_valid) begin
        shift_reg <= word;
        bit_cnt   <= bit_cnt + 3'd1;
      end

      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;

      unique case ({accept, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase

      if (push && full && !pop) overflow <= 1'b1;

      if (spike_valid && spike_in &&
          spike_total != 16'hFFFF)
        spike_total <= spike_total + 16'd1;
    end
  end

endmodule

// File: tb/tb_spike_packer.sv
// Directed self-checking bench for spike_packer.
// Each task drives one scenario and checks its own results.
module tb_spike_packer;

  logic        CLK100MHZ;
  logic        reset_n;
  logic        spike_in;
  logic        spike_valid;
  logic        flush;
  logic        full;
  logic        overflow;
  logic [15:0] spike_total;

  int checks;
  int errors;

  spike_packer_if bus ();

  spike_packer #(.DEPTH(4)) dut (
    .CLK100MHZ   (CLK100MHZ),
    .reset_n     (reset_n),
    .spike_in    (spike_in),
    .spike_valid (spike_valid),
    .flush       (flush),
    .bus         (bus.master),
    .full        (full),
    .overflow    (overflow),
    .spike_total (spike_total)
  );

  initial CLK100MHZ = 1'b0;
  always #5 CLK100MHZ = ~CLK100MHZ;

  task automatic send_bit(input logic b, input logic f);
    @(negedge CLK100MHZ);
    spike_in    = b;
    spike_valid = 1'b1;
    flush       = f;
    @(posedge CLK100MHZ);
    #1;
    spike_valid = 1'b0;
    spike_in    = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i], 1'b0);
  endtask

  task automatic do_flush();
    @(negedge CLK100MHZ);
    flush = 1'b1;
    @(posedge CLK100MHZ);
    #1;
    flush = 1'b0;
  endtask

  task automatic do_pop();
    @(negedge CLK100MHZ);
    bus.out_ready = 1'b1;
    @(posedge CLK100MHZ);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic hard_reset();
    @(negedge CLK100MHZ);
    reset_n = 1'b0;
    @(negedge CLK100MHZ);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n       = 1'b0;
    spike_in      = 1'b1;
    spike_valid   = 1'b1;
    flush         = 1'b1;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge CLK100MHZ);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'd0 ||
        bus.out_count !== 4'd0) begin
      errors++;
      $display("FAIL reset_out: v=%b d=%h c=%0d want 0/00/0",
               bus.out_valid, bus.out_data, bus.out_count);
    end
    checks++;
    if (full !== 1'b0 || overflow !== 1'b0 ||
        spike_total !== 16'd0) begin
      errors++;
      $display("FAIL reset_flags: full=%b ovf=%b tot=%0d want 0/0/0",
               full, overflow, spike_total);
    end
    @(negedge CLK100MHZ);
    spike_in    = 1'b0;
    spike_valid = 1'b0;
    flush       = 1'b0;
    reset_n     = 1'b1;
  endtask

  task automatic test_full_word();
    logic [7:0] seq;
    seq = 8'b1000_1101;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK100MHZ);
      spike_in    = seq[i];
      spike_valid = 1'b1;
      @(posedge CLK100MHZ);
      #1;
      spike_valid = 1'b0;
      if (i < 7) begin
        checks++;
        if (bus.out_valid !== 1'b0) begin
          errors++;
          $display("FAIL word_early: bit %0d valid=%b want 0",
                   i, bus.out_valid);
        end
      end
    end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h8D ||
        bus.out_count !== 4'd8) begin
      errors++;
      $display("FAIL word_8d: v=%b d=%h c=%0d want 1/8d/8",
               bus.out_valid, bus.out_data, bus.out_count);
    end
    checks++;
    if (spike_total !== 16'd4) begin
      errors++;
      $display("FAIL word_total: got %0d want 4", spike_total);
    end
    @(posedge CLK100MHZ);
    #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'd0) begin
      errors++;
      $display("FAIL word_popped: v=%b d=%h want 0/00",
               bus.out_valid, bus.out_data);
    end
  endtask

  task automatic test_flush();
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_pre: valid=%b want 0", bus.out_valid);
    end
    do_flush();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h03 ||
        bus.out_count !== 4'd3) begin
      errors++;
      $display("FAIL flush_part: v=%b d=%h c=%0d want 1/03/3",
               bus.out_valid, bus.out_data, bus.out_count);
    end
    do_pop();
    do_flush();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_count !== 4'd0) begin
      errors++;
      $display("FAIL flush_empty: v=%b c=%0d want 0/0",
               bus.out_valid, bus.out_count);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] w [5];
    w = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int k = 0; k < 4; k++) send_byte(w[k]);
    checks++;
    if (full !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_full4: full=%b ovf=%b want 1/0",
               full, overflow);
    end
    send_byte(w[4]);
    checks++;
    if (full !== 1'b1 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_drop: full=%b ovf=%b want 1/1",
               full, overflow);
    end
    checks++;
    if (bus.out_data !== 8'h11) begin
      errors++;
      $display("FAIL ovf_hold: d=%h want 11", bus.out_data);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== w[k] ||
          bus.out_count !== 4'd8) begin
        errors++;
        $display("FAIL ovf_drain%0d: v=%b d=%h c=%0d want 1/%h/8",
                 k, bus.out_valid, bus.out_data,
                 bus.out_count, w[k]);
      end
      do_pop();
    end
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'd0 ||
        overflow !== 1'b1 || full !== 1'b0) begin
      errors++;
      $display("FAIL ovf_empty: v=%b d=%h ovf=%b full=%b want 0/00/1/0",
               bus.out_valid, bus.out_data, overflow, full);
    end
    // Packer must be clear after the drop: bit+flush gives one bit.
    send_bit(1'b1, 1'b1);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h01 ||
        bus.out_count !== 4'd1) begin
      errors++;
      $display("FAIL ovf_after: v=%b d=%h c=%0d want 1/01/1",
               bus.out_valid, bus.out_data, bus.out_count);
    end
    do_pop();
  endtask

  task automatic test_full_pop();
    logic [7:0] w [4];
    logic [7:0] nb;
    w  = '{8'h02, 8'h03, 8'h04, 8'h66};
    nb = 8'h66;
    hard_reset();
    send_byte(8'h01);
    for (int k = 0; k < 3; k++) send_byte(w[k]);
    for (int i = 0; i < 7; i++) send_bit(nb[i], 1'b0);
    bus.out_ready = 1'b1;
    send_bit(nb[7], 1'b0);
    bus.out_ready = 1'b0;
    checks++;
    if (full !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL fp_flags: full=%b ovf=%b want 1/0",
               full, overflow);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== w[k]) begin
        errors++;
        $display("FAIL fp_drain%0d: v=%b d=%h want 1/%h",
                 k, bus.out_valid, bus.out_data, w[k]);
      end
      do_pop();
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL fp_empty: valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    send_byte(8'h10);
    send_byte(8'h20);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    @(negedge CLK100MHZ);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'd0 ||
        bus.out_count !== 4'd0 || spike_total !== 16'd0 ||
        full !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: v=%b d=%h c=%0d tot=%0d want zeros",
               bus.out_valid, bus.out_data,
               bus.out_count, spike_total);
    end
    @(negedge CLK100MHZ);
    reset_n = 1'b1;
    send_byte(8'hA5);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5 ||
        bus.out_count !== 4'd8 || spike_total !== 16'd4) begin
      errors++;
      $display("FAIL rst_new: v=%b d=%h c=%0d tot=%0d want 1/a5/8/4",
               bus.out_valid, bus.out_data,
               bus.out_count, spike_total);
    end
    do_pop();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_stale: valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_saturate();
    hard_reset();
    bus.out_ready = 1'b1;
    @(negedge CLK100MHZ);
    spike_in    = 1'b1;
    spike_valid = 1'b1;
    repeat (65534) @(posedge CLK100MHZ);
    #1;
    checks++;
    if (spike_total !== 16'hFFFE) begin
      errors++;
      $display("FAIL sat_fffe: got %h want fffe", spike_total);
    end
    @(posedge CLK100MHZ);
    #1;
    checks++;
    if (spike_total !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_ffff: got %h want ffff", spike_total);
    end
    repeat (5) @(posedge CLK100MHZ);
    #1;
    checks++;
    if (spike_total !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_hold: got %h want ffff", spike_total);
    end
    spike_valid   = 1'b0;
    spike_in      = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_full_word();
    test_flush();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/spike_packer.md
SPIKE_PACKER -- requirements
Module: spike_packer

Interface
REQ-001 Parameter DEPTH, default 4, number of packed-word FIFO entries; SHALL be a power of two, minimum 2.
REQ-002 Port CLK100MHZ  input  1  sole clock; all state SHALL change on its rising edge only.
REQ-003 Port reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port spike_in  input  1  spike bit from the upstream delta encoder.
REQ-005 Port spike_valid  input  1  spike_in is meaningful this cycle and SHALL be consumed.
REQ-006 Port flush  input  1  emit the current partial word.
REQ-007 Port out_ready  input  1  consumer accepts the head word this cycle.
REQ-008 Port out_valid  output  1  the FIFO head word is presented.
REQ-009 Port out_data  output  8  packed spike bits; bit0 is the earliest received.
REQ-010 Port out_count  output  4  number of valid bits in out_data, 1..8.
REQ-011 Port full  output  1  FIFO holds DEPTH words.
REQ-012 Port overflow  output  1  sticky flag: a word was dropped.
REQ-013 Port spike_total  output  16  count of accepted spike_in=1 bits.

Function
REQ-014 Packing: on spike_valid, spike_in SHALL be written to shift_reg[bit_cnt] and bit_cnt (0..7) SHALL increment.
REQ-015 Word completion: when spike_valid arrives with bit_cnt=7, the block SHALL push {shift_reg with the new bit, count=8} into the FIFO and SHALL reset bit_cnt to 0 and shift_reg to 0.
REQ-016 Flush with bit_cnt>0 SHALL push the partial word; unused upper bits SHALL be 0, out_count SHALL equal the number of bits held, and bit_cnt and shift_reg SHALL clear.
REQ-017 Flush with bit_cnt=0 and no simultaneous spike_valid SHALL push nothing.
REQ-018 Simultaneous spike_valid and flush: the bit SHALL be included first, then the word flushed, giving exactly one push (count=8 if the bit completed the word).
REQ-019 Latency: a push at edge N into an empty FIFO SHALL make out_valid=1 immediately after edge N.
REQ-020 FIFO pop SHALL occur on edges where out_valid=1 and out_ready=1; words SHALL leave in push order.
REQ-021 out_data and out_count SHALL be held stable while out_valid=1 and out_ready=0.
REQ-022 out_data and out_count SHALL read 0 whenever out_valid=0.
REQ-023 full SHALL be 1 exactly when the occupancy equals DEPTH.
REQ-024 A push while full with no pop in the same cycle SHALL be dropped; overflow SHALL set and remain set until reset.
REQ-025 A push while full together with a pop in the same cycle SHALL be accepted; occupancy SHALL stay at DEPTH and overflow SHALL be unchanged.
REQ-026 A dropped word SHALL still clear bit_cnt and shift_reg, so packing continues on the next bit.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH; occupancy SHALL be tracked with log2(DEPTH)+1 bits.
REQ-028 spike_total SHALL increment by one per accepted spike_in=1 and SHALL saturate at 16'hFFFF, not wrap.

Reset
REQ-029 reset_n=0 SHALL immediately, without waiting for a clock edge, force:
  - out_valid=0, out_data=0, out_count=0
  - full=0, overflow=0, spike_total=0
  - bit_cnt=0, shift_reg=0
  - FIFO pointers and occupancy to 0
REQ-030 Reset asserted mid-word or with a non-empty FIFO SHALL discard all held data; no stale word SHALL appear after release.
REQ-031 Inputs SHALL be ignored while reset_n=0; the first edge after release SHALL process inputs normally.

Verification
REQ-032 Spike sequence 1,0,1,1,0,0,0,1 with spike_valid=1 and out_ready=1 -> out_valid=1 one edge after the 8th bit, out_data=8'h8D, out_count=8, spike_total=4.
REQ-033 Spike sequence 1,1,0, then flush -> out_data=8'h03, out_count=3; a following flush with no bits -> no push.
REQ-034 out_ready=0 and 5 full words pushed (DEPTH=4) -> full=1 after the 4th, 5th dropped, overflow=1; draining yields the first four in order, then out_valid=0 and out_data=0.
REQ-035 FIFO full, out_ready=1 and a word completing on the same edge -> word accepted, full stays 1, overflow stays 0.
REQ-036 reset_n pulsed low with bit_cnt=5 and 2 words queued -> all outputs 0 before the next edge; after release, 8 more bits yield exactly one word containing only the new bits.
REQ-037 More than 65535 spike_in=1 bits -> spike_total holds at 16'hFFFF.
